// File: rtl/bp_fe_bp_pkg.sv
// Shared branch-predictor definitions: 2-bit saturating counter type, its
// canonical values, the PHT init-sweep FSM states and the counter update rule.
// Used by the gshare PHT and reusable by the bimodal/tournament predictors.
package bp_fe_bp_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'b00;  // strongly not-taken
  localparam ctr2_t CTR_WNT = 2'b01;  // weakly not-taken (init value)
  localparam ctr2_t CTR_ST  = 2'b11;  // strongly taken

  typedef enum logic [0:0] {INIT, READY} pht_state_e;

  // Saturating +1 on taken, -1 on not-taken.
  function automatic ctr2_t sat_update(ctr2_t ctr, logic taken);
    ctr2_t res;
    if (taken) begin
      res = (ctr == CTR_ST) ? ctr : ctr + 2'b01;
    end else begin
      res = (ctr == CTR_SNT) ? ctr : ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_fe_gshare_pht.sv
// Gshare pattern history table.
// Indexes 2^IDX_W two-bit counters with (PC slice XOR global history) and
// returns a registered taken/not-taken prediction one cycle after a lookup.
// After reset an INIT sweep writes every entry to weakly not-taken, one per
// cycle; lookups and updates are ignored until ready_o rises.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ready_o            table initialised and accepting requests
//   lookup_v_i/_pc_i   lookup request and fetch PC
//   global_history_i   current global history
//   pred_v_o           prediction valid (one cycle after lookup)
//   pred_taken_o       predicted direction (holds when no lookup)
//   pred_idx_o         table index used, checkpointed by the backend
//   update_v_i/_idx_i/_taken_i  training request from branch resolution
//
// Optional build macro GSHARE_BYPASS_EN: a same-cycle lookup and update to
// the same index returns the post-update counter MSB instead of the
// pre-update one. Counter contents are identical in both builds.
module bp_fe_gshare_pht
  import bp_fe_bp_pkg::*;
#(
  parameter int unsigned PC_W   = 39,
  parameter int unsigned IDX_W  = 12,
  parameter int unsigned PC_LSB = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready_o,
  input  logic             lookup_v_i,
  input  logic [PC_W-1:0]  lookup_pc_i,
  input  logic [IDX_W-1:0] global_history_i,
  output logic             pred_v_o,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             update_v_i,
  input  logic [IDX_W-1:0] update_idx_i,
  input  logic             update_taken_i
);

  localparam int unsigned Depth = 2 ** IDX_W;

  pht_state_e       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             init_we;

  ctr2_t            pht_q [Depth];

  logic             is_ready;
  logic [IDX_W-1:0] lookup_idx;
  ctr2_t            rd_ctr, upd_ctr, upd_next;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  ctr2_t            tbl_wdata;
  logic             pred_msb;
  logic             do_lookup;

  logic             pred_v_q, pred_taken_q;
  logic [IDX_W-1:0] pred_idx_q;

  // Only a slice of the PC feeds the hash.
  logic unused_pc;
  assign unused_pc = ^lookup_pc_i;

  // Init sweep FSM.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    init_we = 1'b0;
    unique case (state_q)
      INIT: begin
        init_we = 1'b1;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = READY;
      end
      READY: ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign is_ready   = (state_q == READY);
  assign ready_o    = is_ready;
  assign do_lookup  = is_ready & lookup_v_i;
  assign lookup_idx = lookup_pc_i[PC_LSB +: IDX_W] ^ global_history_i;

  // Read-modify-write of the training counter at the clock edge.
  assign rd_ctr   = pht_q[lookup_idx];
  assign upd_ctr  = pht_q[update_idx_i];
  assign upd_next = sat_update(upd_ctr, update_taken_i);

  assign tbl_we    = init_we | (is_ready & update_v_i);
  assign tbl_waddr = init_we ? sweep_q : update_idx_i;
  assign tbl_wdata = init_we ? CTR_WNT : upd_next;

  // Table contents are defined by the init sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (tbl_we) pht_q[tbl_waddr] <= tbl_wdata;
  end

`ifdef GSHARE_BYPASS_EN
  assign pred_msb = (update_v_i && (update_idx_i == lookup_idx)) ? upd_next[1] : rd_ctr[1];
`else
  assign pred_msb = rd_ctr[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_v_q     <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      pred_v_q <= do_lookup;
      if (do_lookup) begin
        pred_taken_q <= pred_msb;
        pred_idx_q   <= lookup_idx;
      end
    end
  end

  assign pred_v_o     = pred_v_q;
  assign pred_taken_o = pred_taken_q;
  assign pred_idx_o   = pred_idx_q;

endmodule

// File: tb/tb_bp_fe_gshare_pht.sv
// Directed bench for bp_fe_gshare_pht: init sweep length, hash, counter
// training and saturation, same-cycle lookup/update ordering, reset mid-INIT.
module tb_bp_fe_gshare_pht;

  localparam int unsigned PC_W  = 39;
  localparam int unsigned IDX_W = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ready_o;
  logic             lookup_v_i;
  logic [PC_W-1:0]  lookup_pc_i;
  logic [IDX_W-1:0] global_history_i;
  logic             pred_v_o;
  logic             pred_taken_o;
  logic [IDX_W-1:0] pred_idx_o;
  logic             update_v_i;
  logic [IDX_W-1:0] update_idx_i;
  logic             update_taken_i;

  int checks = 0;
  int passed = 0;

`ifdef GSHARE_BYPASS_EN
  localparam logic ExpSameCycle = 1'b1;
`else
  localparam logic ExpSameCycle = 1'b0;
`endif

  bp_fe_gshare_pht #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W),
    .PC_LSB(2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ready_o         (ready_o),
    .lookup_v_i      (lookup_v_i),
    .lookup_pc_i     (lookup_pc_i),
    .global_history_i(global_history_i),
    .pred_v_o        (pred_v_o),
    .pred_taken_o    (pred_taken_o),
    .pred_idx_o      (pred_idx_o),
    .update_v_i      (update_v_i),
    .update_idx_i    (update_idx_i),
    .update_taken_i  (update_taken_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: optional lookup and optional update, then sample at edge+1.
  task automatic step(input logic lv, input logic [PC_W-1:0] pc, input logic [IDX_W-1:0] hist,
                      input logic uv, input logic [IDX_W-1:0] uidx, input logic ut);
    lookup_v_i       = lv;
    lookup_pc_i      = pc;
    global_history_i = hist;
    update_v_i       = uv;
    update_idx_i     = uidx;
    update_taken_i   = ut;
    @(posedge clk);
    #1;
    lookup_v_i = 1'b0;
    update_v_i = 1'b0;
  endtask

  task automatic lookup(input logic [PC_W-1:0] pc, input logic [IDX_W-1:0] hist);
    step(1'b1, pc, hist, 1'b0, '0, 1'b0);
  endtask

  task automatic train(input logic [IDX_W-1:0] idx, input logic t);
    step(1'b0, '0, '0, 1'b1, idx, t);
  endtask

  // Lookup with history 0 so the index equals pc[13:2].
  task automatic probe(input string tag, input logic [IDX_W-1:0] idx, input logic exp_t);
    logic [PC_W-1:0] pc;
    pc = {{(PC_W-IDX_W-2){1'b0}}, idx, 2'b00};
    lookup(pc, '0);
    check({tag, "_v"}, {31'd0, pred_v_o}, 32'd1);
    check({tag, "_idx"}, {20'd0, pred_idx_o}, {20'd0, idx});
    check({tag, "_taken"}, {31'd0, pred_taken_o}, {31'd0, exp_t});
  endtask

  int  cnt;
  logic saw_pv;

  initial begin
    rst_n = 1'b0;
    lookup_v_i = 1'b0; lookup_pc_i = '0; global_history_i = '0;
    update_v_i = 1'b0; update_idx_i = '0; update_taken_i = 1'b0;
    #22;
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_pred_v", {31'd0, pred_v_o}, 32'd0);
    check("rst_pred_taken", {31'd0, pred_taken_o}, 32'd0);
    check("rst_pred_idx", {20'd0, pred_idx_o}, 32'd0);

    // 1. Init sweep lasts exactly 4096 cycles.
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (ready_o !== 1'b1 && cnt < 5000) begin
      @(posedge clk); #1; cnt++;
    end
    check("init_len", cnt, 32'd4096);

    // Sampled entries are exactly 01: MSB 0, and one taken update flips it.
    probe("init_123_a", 12'h123, 1'b0); train(12'h123, 1'b1); probe("init_123_b", 12'h123, 1'b1);
    train(12'h123, 1'b0);
    probe("init_fff_a", 12'hfff, 1'b0); train(12'hfff, 1'b1); probe("init_fff_b", 12'hfff, 1'b1);
    train(12'hfff, 1'b0);
    probe("init_001_a", 12'h001, 1'b0);

    // 2. pc=0x1000, hist=0 -> idx 0x400, not taken.
    lookup(39'h1000, 12'h000);
    check("t2_v", {31'd0, pred_v_o}, 32'd1);
    check("t2_idx", {20'd0, pred_idx_o}, 32'h400);
    check("t2_taken", {31'd0, pred_taken_o}, 32'd0);

    // Idle cycle: valid drops, index/direction hold.
    step(1'b0, '0, '0, 1'b0, '0, 1'b0);
    check("idle_v", {31'd0, pred_v_o}, 32'd0);
    check("idle_idx", {20'd0, pred_idx_o}, 32'h400);

    // 3. Training with back-to-back updates: 01 ->11 (sat) ->10 ->01.
    train(12'h400, 1'b1); train(12'h400, 1'b1);
    probe("t3_two_t", 12'h400, 1'b1);
    train(12'h400, 1'b1); train(12'h400, 1'b1); train(12'h400, 1'b1);
    train(12'h400, 1'b0);
    probe("t3_one_nt", 12'h400, 1'b1);
    train(12'h400, 1'b0);
    probe("t3_two_nt", 12'h400, 1'b0);

    // Low saturation: 01 -> 00 (x3, sat) -> 01 -> 10.
    train(12'h0ab, 1'b0); train(12'h0ab, 1'b0); train(12'h0ab, 1'b0);
    train(12'h0ab, 1'b1);
    probe("sat_lo_a", 12'h0ab, 1'b0);
    train(12'h0ab, 1'b1);
    probe("sat_lo_b", 12'h0ab, 1'b1);

    // 4. Hash: pc=0x1000 ^ hist=0x400 -> idx 0.
    lookup(39'h1000, 12'h400);
    check("t4_idx", {20'd0, pred_idx_o}, 32'h000);
    check("t4_taken", {31'd0, pred_taken_o}, 32'd0);

    // 5. Same-cycle lookup and taken update at 0x400 (counter 01).
    step(1'b1, 39'h1000, 12'h000, 1'b1, 12'h400, 1'b1);
    check("t5_same_idx", {20'd0, pred_idx_o}, 32'h400);
    check("t5_same_taken", {31'd0, pred_taken_o}, {31'd0, ExpSameCycle});
    probe("t5_after", 12'h400, 1'b1);
    // Different index in the same cycle: independent (0x400 back to 01).
    step(1'b1, 39'h1554, 12'h000, 1'b1, 12'h400, 1'b0);
    check("t5_diff_idx", {20'd0, pred_idx_o}, 32'h555);
    check("t5_diff_taken", {31'd0, pred_taken_o}, 32'd0);
    probe("t5_diff_after", 12'h400, 1'b0);

    // 6. Reset, then reset again at cycle 2000 of INIT.
    #1; rst_n = 1'b0; #1;
    check("rst2_ready", {31'd0, ready_o}, 32'd0);
    check("rst2_pred_idx", {20'd0, pred_idx_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2000) @(posedge clk);
    #2;
    check("init_2000_ready", {31'd0, ready_o}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lookup_v_i = 1'b1; lookup_pc_i = 39'h1000; global_history_i = '0;
    update_v_i = 1'b1; update_idx_i = 12'h0ab; update_taken_i = 1'b1;
    cnt = 0; saw_pv = 1'b0;
    while (ready_o !== 1'b1 && cnt < 5000) begin
      @(posedge clk); #1; cnt++;
      if (pred_v_o !== 1'b0) saw_pv = 1'b1;
    end
    lookup_v_i = 1'b0; update_v_i = 1'b0;
    check("reinit_len", cnt, 32'd4096);
    check("init_no_pred", {31'd0, saw_pv}, 32'd0);
    // 0x0ab was 10 before; the resweep restores it to 01.
    probe("reinit_0ab", 12'h0ab, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
